nonce_result_queue: RTL and testbench

Buffers 64-bit results from the miner cores and paces them into the 64-bit serial transmit stage. The transmit stage takes one 8-byte message per `NewValidInput` pulse and has no ready/busy output. This block therefore enforces a fixed inter-message gap long enough for a full message to drain before it issues the next one. It sits between the core result arbiter (upstream) and the serial TX stage (downstream).

---
 rtl/nxs_serial_pkg.sv | 25 ++
 rtl/result_fifo.sv | 59 +++++
 rtl/nonce_result_queue.sv | 109 ++++++++++
 tb/tb_nonce_result_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nxs_serial_pkg.sv
// Shared constants for the nonce serial path: message geometry, queue FSM encodings, default TX pacing.
package nxs_serial_pkg;

  localparam int MSG_BYTES = 8;
  localparam int RESULT_W  = MSG_BYTES * 8;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 115_200;

  typedef logic [1:0] q_state_t;
  localparam logic [1:0] Q_IDLE  = 2'd0;
  localparam logic [1:0] Q_ISSUE = 2'd1;
  localparam logic [1:0] Q_GAP   = 2'd2;

  // Nine 10-bit UART frames (message plus one spare byte) with a 1024/1000 margin;
  // 100 MHz at 115200 baud gives exactly 80000.
  function automatic int gap_cycles(input longint clk_hz, input longint baud);
    longint frame_clks;
    frame_clks = longint'(MSG_BYTES + 1) * 64'd10 * clk_hz / baud;
    return int'(frame_clks * 64'd1024 / 64'd1000);
  endfunction

  localparam int GAP_CYCLES_DEFAULT = gap_cycles(CLK_HZ, BAUD);

endpackage

// File: rtl/result_fifo.sv
// Circular result buffer; head is combinational, empty/full are registered from the next occupancy.
// Push and pop land on the same edge; the caller must not push when full unless it also pops.
module result_fifo
  import nxs_serial_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = RESULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/nonce_result_queue.sv
// Queues miner results and issues one per GAP_CYCLES to the TX stage; RESULT_DEDUP_EN drops repeats of the last accepted word.
// Issue pulse 2 clocks after a push into an idle empty queue; no backpressure upstream, rejected results bump DropCount.
module nonce_result_queue
  import nxs_serial_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ResultValid,
  input  logic [RESULT_W-1:0] ResultData,
  output logic                NewValidInput,
  output logic [RESULT_W-1:0] OutData,
  output logic                Empty,
  output logic                Full,
  output logic [7:0]          DropCount
);

  localparam int GW = $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 2);

  q_state_t            state;
  logic [GW-1:0]       gap_cnt;
  logic [RESULT_W-1:0] head;
  logic                pop;
  logic                push;
  logic                room;
  logic                dup;
  logic                drop;

  assign pop  = (state == Q_IDLE) && !Empty;
  assign room = !Full || pop;

`ifdef RESULT_DEDUP_EN
  logic [RESULT_W-1:0] last_word;
  logic                last_vld;

  assign dup = last_vld && (ResultData == last_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word <= '0;
      last_vld  <= 1'b0;
    end else if (push) begin
      last_word <= ResultData;
      last_vld  <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push = ResultValid && room && !dup;
  assign drop = ResultValid && !push;

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (RESULT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ResultData),
    .pop       (pop),
    .head      (head),
    .empty     (Empty),
    .full      (Full)
  );

  // ISSUE + (GAP_CYCLES-2) GAP cycles + IDLE spaces back-to-back pulses by exactly GAP_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= Q_IDLE;
      gap_cnt       <= '0;
      OutData       <= '0;
      NewValidInput <= 1'b0;
    end else begin
      NewValidInput <= 1'b0;
      case (state)
        Q_IDLE: begin
          if (!Empty) begin
            OutData       <= head;
            NewValidInput <= 1'b1;
            state         <= Q_ISSUE;
          end
        end
        Q_ISSUE: begin
          gap_cnt <= GAP_LOAD;
          state   <= Q_GAP;
        end
        Q_GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt <= GW'(1)) state <= Q_IDLE;
        end
        default: state <= Q_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DropCount <= '0;
    end else if (drop && (DropCount != 8'hFF)) begin
      DropCount <= DropCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_nonce_result_queue.sv
// Directed bench for nonce_result_queue with a scoreboard of expected issued words.
module tb_nonce_result_queue;

  localparam int DEPTH = 8;
  localparam int GAP   = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ResultValid;
  logic [63:0] ResultData;
  logic        NewValidInput;
  logic [63:0] OutData;
  logic        Empty;
  logic        Full;
  logic [7:0]  DropCount;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int npulse = 0;
  logic [63:0] exp_q[$];
  int pulse_cyc[$];
  logic [63:0] last_issued = '0;
  bit have_issued = 0;
  bit prev_nvi = 0;

  nonce_result_queue #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ResultValid   (ResultValid),
    .ResultData    (ResultData),
    .NewValidInput (NewValidInput),
    .OutData       (OutData),
    .Empty         (Empty),
    .Full          (Full),
    .DropCount     (DropCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_nvi"},   64'(NewValidInput), 64'd0);
    check({tag, "_data"},  OutData,            64'd0);
    check({tag, "_empty"}, 64'(Empty),         64'd1);
    check({tag, "_full"},  64'(Full),          64'd0);
    check({tag, "_drop"},  64'(DropCount),     64'd0);
  endtask

  task automatic push(input logic [63:0] d, input bit accept);
    ResultValid = 1'b1;
    ResultData  = d;
    if (accept) exp_q.push_back(d);
    @(posedge clk); #1;
    ResultValid = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int b;
    b = budget;
    while (npulse < target && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    check("pulse_count", 64'(npulse), 64'(target));
  endtask

  task automatic check_spacing(input string tag);
    int k;
    k = pulse_cyc.size();
    if (k >= 2) check(tag, 64'(pulse_cyc[k-1] - pulse_cyc[k-2]), 64'(GAP));
  endtask

  // Scoreboard: every issue pulse must carry the oldest expected word; OutData must hold between pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_issued = 0;
      prev_nvi    = 0;
    end else begin
      if (NewValidInput) begin
        npulse++;
        pulse_cyc.push_back(cyc);
        check("pulse_single", 64'(prev_nvi), 64'd0);
        check("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          last_issued = exp_q.pop_front();
          have_issued = 1;
          check("issue_data", OutData, last_issued);
        end
      end else if (have_issued) begin
        check("outdata_hold", OutData, last_issued);
      end
      prev_nvi = NewValidInput;
    end
  end

  initial begin
    int n0;
    rst_n       = 1'b0;
    ResultValid = 1'b0;
    ResultData  = '0;
    @(posedge clk); #1;
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single push: pulse 2 clocks after the push edge, queue drains back to empty.
    push(64'h0123_4567_89AB_CDEF, 1);
    @(posedge clk); #1;
    check("t1_nvi",   64'(NewValidInput), 64'd1);
    check("t1_data",  OutData, 64'h0123_4567_89AB_CDEF);
    check("t1_empty", 64'(Empty), 64'd1);
    @(posedge clk); #1;
    check("t1_nvi_low", 64'(NewValidInput), 64'd0);
    repeat (GAP) @(posedge clk);
    #1;

    // Three back-to-back pushes: pulses GAP apart, in order.
    n0 = npulse;
    push(64'hAAAA_0000_0000_000A, 1);
    push(64'hBBBB_0000_0000_000B, 1);
    push(64'hCCCC_0000_0000_000C, 1);
    wait_pulses(n0 + 3, 4 * GAP + 10);
    check_spacing("t2_space_bc");
    if (pulse_cyc.size() >= 3)
      check("t2_space_ab", 64'(pulse_cyc[pulse_cyc.size()-2] - pulse_cyc[pulse_cyc.size()-3]), 64'(GAP));
    check("t2_empty", 64'(Empty), 64'd1);
    repeat (GAP) @(posedge clk);
    #1;

    // Ten pushes inside one gap: DEPTH accepted, two dropped.
    push(64'h5555_0000_0000_0001, 1);
    wait_pulses(npulse + 1, 10);
    for (int i = 0; i < 10; i++) push(64'hB000_0000_0000_0000 | 64'(i), i < DEPTH);
    check("t3_full", 64'(Full), 64'd1);
    check("t3_drop", 64'(DropCount), 64'd2);

    // Push while full on the IDLE pop edge: accepted, no drop, order kept across wrap.
    repeat (8) @(posedge clk);
    #1;
    n0 = npulse;
    push(64'hFEED_FACE_0000_0009, 1);
    check("t4_full", 64'(Full), 64'd1);
    check("t4_drop", 64'(DropCount), 64'd2);
    wait_pulses(n0 + 9, 9 * GAP + 20);
    check_spacing("t4_space");
    check("t4_drained", 64'(exp_q.size()), 64'd0);
    check("t4_total", 64'(npulse - n0 - 1 + int'(DropCount)), 64'd10);
    repeat (GAP) @(posedge clk);
    #1;

    // Reset mid-gap with four entries still queued.
    for (int i = 0; i < 5; i++) push(64'hD000_0000_0000_0000 | 64'(i), 1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("t5_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = npulse;
    repeat (3 * GAP) @(posedge clk);
    #1;
    check("t5_no_pulse", 64'(npulse), 64'(n0));
    check("t5_empty", 64'(Empty), 64'd1);
    check("t5_data",  OutData, 64'd0);
    push(64'h7777_0000_0000_0777, 1);
    @(posedge clk); #1;
    check("t5_new_nvi",  64'(NewValidInput), 64'd1);
    check("t5_new_data", OutData, 64'h7777_0000_0000_0777);
    @(negedge clk); #1;

    // Duplicate handling: X, X, Y.
    n0 = npulse;
`ifdef RESULT_DEDUP_EN
    push(64'h1111_2222_3333_4444, 1);
    push(64'h1111_2222_3333_4444, 0);
    push(64'h9999_8888_7777_6666, 1);
    wait_pulses(n0 + 2, 4 * GAP + 10);
    check("t6_drop", 64'(DropCount), 64'd1);
`else
    push(64'h1111_2222_3333_4444, 1);
    push(64'h1111_2222_3333_4444, 1);
    push(64'h9999_8888_7777_6666, 1);
    wait_pulses(n0 + 3, 4 * GAP + 10);
    check("t6_drop", 64'(DropCount), 64'd0);
`endif
    check("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
